prbs11_g4_check: RTL and testbench
==================================

Name: prbs11_g4_check

Overview:
- Receive-side counterpart of the Gen4 PRBS11 lane sender.
- Samples one serial bit per clock during Gen4 lane training and checks the first 11 bits against the lane seed.
- Self-synchronises an 11-bit reference LFSR, then checks every later bit against the prediction.
- Frames the stream into 448-bit ordered sets and reports per-set pass/fail to the training FSM.

Parameters:
- lane0_lane1, 1, selects the expected seed: 1 gives 11'h7FF (lane 0), 0 gives 11'h770 (lane 1).
- LOSS_THRESH, 4, number of consecutive mismatched bits that drops lock (legal range 1..15).

Ports:
- clk  input  1  bit clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  checker enable, registered internally exactly as on the send side
- data_in  input  1  serial PRBS bit
- locked  output  1  reference LFSR is synchronised
- os_received  output  1  one-cycle pulse: an error-free 448-bit set completed while locked
- block_err  output  1  one-cycle pulse: a 448-bit set completed with errors or without lock
- err_cnt  output  8  mismatches in the current set, saturates at 8'hFF
- seed_err  output  1  sticky flag: the first 11 bits after enable did not equal the seed

Behaviour:
- Reset values: all outputs 0; en_q=0; state=IDLE; hist=0; bit_cnt=0; acq_cnt=0; miss_run=0.
- en_q is enable registered by one cycle. data_in is sampled only on posedges where en_q=1. The first such sample is bit index 0.
- Timing contract: sender.data_out wired to data_in with a shared enable means bit 0 equals seed[10]. The 11 bits are sent MSB first, so after 11 samples hist == seed.
- hist: 11-bit shift register; newest bit enters hist[0], shifted left.
- Predicted next bit = hist[10]^hist[8]. This is the same polynomial as the sender, x^11+x^9+1.
- en_q=0 at any time (including mid-set) forces the following state on the next posedge:
  - state=IDLE
  - locked=0, err_cnt=0, seed_err=0
  - bit_cnt=0, acq_cnt=0, miss_run=0
  - no os_received or block_err pulse is produced.
- FSM:
  - IDLE: if en_q, sample bit 0 into hist, set acq_cnt=1 and go to ACQUIRE.
  - ACQUIRE: shift data_in into hist and increment acq_cnt. On the sample that makes acq_cnt=11, go to LOCKED (locked=1 from the next cycle).
  - First acquisition after enable only: if the completed hist != seed, set seed_err=1.
  - LOCKED: compare data_in with the prediction, then shift data_in into hist.
    - On mismatch: err_cnt+1 (saturating) and miss_run+1.
    - On match: miss_run=0.
    - When miss_run reaches LOSS_THRESH: go to ACQUIRE with acq_cnt=0 and locked=0. err_cnt keeps its value.
  - Re-acquisition (after lock loss): re-collect 11 bits and do not re-check the seed.
- Framing:
  - bit_cnt (9 bit) counts sampled bits 0..447 (9'h1BF), then wraps to 0. It runs independently of lock.
  - On the posedge that samples bit 447:
    - next cycle, pulse os_received=1 if the state stayed LOCKED for the whole set and err_cnt (including this bit) is 0;
    - otherwise pulse block_err=1;
    - err_cnt clears to 0 on the same edge.
  - The first set always reports block_err=0 unless it had a mismatch or a seed error. Bits 0..10 are acquisition bits and count as valid.
  - A set that contains a seed error reports block_err.
  - Exactly one of os_received/block_err pulses per completed set.
- Bits sampled while in ACQUIRE are never counted as mismatches. However, a set that contains any ACQUIRE cycle after the first 11 bits reports block_err.
- Latency: a mismatch is visible on err_cnt one cycle after the sampling edge.
- Simultaneous events:
  - Lock loss on bit 447: block_err pulses and err_cnt clears, then re-acquisition starts with bit 0 of the next set.
  - Saturation: err_cnt holds at 8'hFF until the set ends.

Decomposition:
- Shared package prbs11_g4_pkg holds:
  - seed constants SEED_LANE0=11'h7FF and SEED_LANE1=11'h770;
  - OS_LAST=9'h1BF;
  - tap indices 10 and 8.
- The send block uses the same package.
- One sub-module is natural: prbs11_g4_frame_cnt. It holds the 9-bit wrap counter and the end-of-set strobe, and is shared with the sender's os_sent logic.

Test Plan:
- Lane 0, sender→checker, enable held for 896 bits: first 11 bits are 1, bit 11 is 0. Expect locked=1 from the cycle after bit 10, os_received pulses twice 448 bits apart, block_err=0 throughout, seed_err=0.
- Lane 1 (lane0_lane1=0) checker fed by a lane-0 sender: seed_err=1 after bit 10. Expect locked=1 and block_err to pulse at the first set end (no os_received).
- Single bit flip at bit 200, lane 0: err_cnt=1 the cycle after, locked stays 1, block_err pulses at set end, the next set gives os_received.
- Invert 4 consecutive bits at 300..303 with LOSS_THRESH=4: locked=0 after bit 303, re-lock 11 bits later, err_cnt=4 at set end, block_err pulses. The following set gives os_received.
- Deassert enable at bit 250 and reassert 20 cycles later: all outputs 0 during the gap, no pulse, bit_cnt restarts at 0. A clean set then yields os_received 448 bits after re-enable.
- Assert reset low mid-LOCKED asynchronously: all outputs 0 immediately, state=IDLE.

Source files
------------

// File: rtl/prbs11_g4_pkg.sv
// Shared constants and types for the Gen4 PRBS11 lane sender and checker.
// Polynomial x^11 + x^9 + 1, 448-bit ordered-set framing.
package prbs11_g4_pkg;

    localparam logic [10:0] SEED_LANE0 = 11'h7FF;
    localparam logic [10:0] SEED_LANE1 = 11'h770;
    localparam logic [8:0]  OS_LAST    = 9'h1BF;
    localparam int          TAP_HI     = 10;
    localparam int          TAP_LO     = 8;
    localparam logic [3:0]  ACQ_LAST   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } chk_state_e;

    function automatic logic prbs11_next(input logic [10:0] hist);
        return hist[TAP_HI] ^ hist[TAP_LO];
    endfunction

endpackage

// File: rtl/prbs11_g4_frame_cnt.sv
// 448-bit ordered-set position counter with an end-of-set strobe.
// Shared by the PRBS11 sender and checker so both frame identically.
module prbs11_g4_frame_cnt
    import prbs11_g4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [8:0] bit_cnt,
    output logic       set_last
);

    logic [8:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (advance) begin
            cnt_reg <= (cnt_reg == OS_LAST) ? 9'd0 : cnt_reg + 9'd1;
        end
    end

    assign bit_cnt  = cnt_reg;
    assign set_last = advance && (cnt_reg == OS_LAST);

endmodule

// File: rtl/prbs11_g4_check.sv
// Gen4 PRBS11 lane checker: self-synchronising reference LFSR, seed check,
// lock tracking and per-ordered-set pass/fail reporting.
module prbs11_g4_check
    import prbs11_g4_pkg::*;
#(
    parameter bit lane0_lane1 = 1'b1,
    parameter int LOSS_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_in,
    output logic       locked,
    output logic       os_received,
    output logic       block_err,
    output logic [7:0] err_cnt,
    output logic       seed_err
);

    localparam logic [10:0] SEED   = lane0_lane1 ? SEED_LANE0 : SEED_LANE1;
    localparam logic [3:0]  THRESH = 4'(LOSS_THRESH);

    logic        en_q_reg;
    chk_state_e  state_reg, state_next;
    logic [10:0] hist_reg, hist_next;
    logic [3:0]  acq_cnt_reg, acq_cnt_next;
    logic [3:0]  miss_run_reg, miss_run_next;
    logic [7:0]  err_cnt_reg, err_cnt_next;
    logic        seed_err_reg, seed_err_next;
    logic        first_acq_reg, first_acq_next;
    logic        set_bad_reg, set_bad_next;
    logic        os_reg, os_next;
    logic        blk_reg, blk_next;
    logic [7:0]  err_sum;
    logic        bad_sum;
    logic [8:0]  bit_cnt;
    logic        set_last;

    prbs11_g4_frame_cnt u_frame_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (!en_q_reg),
        .advance  (en_q_reg),
        .bit_cnt  (bit_cnt),
        .set_last (set_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
            hist_reg      <= '0;
            acq_cnt_reg   <= '0;
            miss_run_reg  <= '0;
            err_cnt_reg   <= '0;
            seed_err_reg  <= 1'b0;
            first_acq_reg <= 1'b1;
            set_bad_reg   <= 1'b0;
            os_reg        <= 1'b0;
            blk_reg       <= 1'b0;
        end else begin
            en_q_reg      <= enable;
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            acq_cnt_reg   <= acq_cnt_next;
            miss_run_reg  <= miss_run_next;
            err_cnt_reg   <= err_cnt_next;
            seed_err_reg  <= seed_err_next;
            first_acq_reg <= first_acq_next;
            set_bad_reg   <= set_bad_next;
            os_reg        <= os_next;
            blk_reg       <= blk_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        acq_cnt_next   = acq_cnt_reg;
        miss_run_next  = miss_run_reg;
        err_cnt_next   = err_cnt_reg;
        seed_err_next  = seed_err_reg;
        first_acq_next = first_acq_reg;
        set_bad_next   = set_bad_reg;
        os_next        = 1'b0;
        blk_next       = 1'b0;
        err_sum        = err_cnt_reg;
        bad_sum        = set_bad_reg;

        if (!en_q_reg) begin
            state_next     = ST_IDLE;
            acq_cnt_next   = '0;
            miss_run_next  = '0;
            err_cnt_next   = '0;
            seed_err_next  = 1'b0;
            first_acq_next = 1'b1;
            set_bad_next   = 1'b0;
        end else begin
            hist_next = {hist_reg[9:0], data_in};
            case (state_reg)
                ST_IDLE: begin
                    acq_cnt_next = 4'd1;
                    state_next   = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    acq_cnt_next = acq_cnt_reg + 4'd1;
                    // Only the opening acquisition of a set is free of penalty.
                    if (bit_cnt > 9'd10) begin
                        bad_sum = 1'b1;
                    end
                    if (acq_cnt_reg == ACQ_LAST) begin
                        state_next     = ST_LOCKED;
                        first_acq_next = 1'b0;
                        if (first_acq_reg && (hist_next != SEED)) begin
                            seed_err_next = 1'b1;
                            bad_sum       = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (data_in != prbs11_next(hist_reg)) begin
                        if (err_cnt_reg != 8'hFF) begin
                            err_sum = err_cnt_reg + 8'd1;
                        end
                        if (miss_run_reg == THRESH - 4'd1) begin
                            state_next    = ST_ACQUIRE;
                            acq_cnt_next  = '0;
                            miss_run_next = '0;
                        end else begin
                            miss_run_next = miss_run_reg + 4'd1;
                        end
                    end else begin
                        miss_run_next = '0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            err_cnt_next = err_sum;
            set_bad_next = bad_sum;
            if (set_last) begin
                os_next      = !bad_sum && (err_sum == 8'd0);
                blk_next     = !(!bad_sum && (err_sum == 8'd0));
                err_cnt_next = '0;
                set_bad_next = 1'b0;
            end
        end
    end

    assign locked      = (state_reg == ST_LOCKED);
    assign os_received = os_reg;
    assign block_err   = blk_reg;
    assign err_cnt     = err_cnt_reg;
    assign seed_err    = seed_err_reg;

endmodule

// File: tb/tb_prbs11_g4_check.sv
// Bench for prbs11_g4_check: a lane-0 and a lane-1 checker share one lane-0
// PRBS11 stream; expectations come from an index-based reference model.
module tb_prbs11_g4_check;

    localparam int LOSS = 4;
    localparam int SET_BITS = 448;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       data_in = 1'b0;
    logic       locked0, os0, blk0, serr0;
    logic       locked1, os1, blk1, serr1;
    logic [7:0] err0, err1;

    always #5 clk = ~clk;

    prbs11_g4_check #(.lane0_lane1(1'b1), .LOSS_THRESH(LOSS)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .locked(locked0), .os_received(os0), .block_err(blk0),
        .err_cnt(err0), .seed_err(serr0)
    );

    prbs11_g4_check #(.lane0_lane1(1'b0), .LOSS_THRESH(LOSS)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .locked(locked1), .os_received(os1), .block_err(blk1),
        .err_cnt(err1), .seed_err(serr1)
    );

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    logic        txs [0:4095];
    logic        rx  [0:4095];
    logic [10:0] m_seed [2];
    logic        m_enq;
    int          m_n;
    int          acq_end [2];
    int          run_len [2];
    int          errs [2];
    logic        bad [2];
    logic        serr_m [2];
    logic        exp_os [2];
    logic        exp_blk [2];
    int          os_seen [2];
    int          blk_seen [2];

    task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s lane_inst=%0d step=%0d observed=%0h expected=%0h", tag, inst, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_enq = 1'b0;
        m_n   = 0;
        for (int i = 0; i < 2; i++) begin
            acq_end[i] = 11; run_len[i] = 0; errs[i] = 0;
            bad[i] = 1'b0; serr_m[i] = 1'b0; exp_os[i] = 1'b0; exp_blk[i] = 1'b0;
        end
    endtask

    // One clock edge of the reference: received bit n is predicted from
    // received bits n-11 and n-9; lock starts at sample index acq_end.
    task automatic model_edge(input logic din);
        logic [10:0] first11;
        int p;
        for (int i = 0; i < 2; i++) begin
            exp_os[i] = 1'b0; exp_blk[i] = 1'b0;
        end
        if (!m_enq) begin
            model_reset();
        end else begin
            rx[m_n] = din;
            p = m_n % SET_BITS;
            for (int i = 0; i < 2; i++) begin
                if (m_n >= acq_end[i]) begin
                    if (din != (rx[m_n-11] ^ rx[m_n-9])) begin
                        errs[i] = (errs[i] < 255) ? errs[i] + 1 : 255;
                        run_len[i]++;
                        if (run_len[i] == LOSS) begin
                            acq_end[i] = m_n + 12;
                            run_len[i] = 0;
                        end
                    end else begin
                        run_len[i] = 0;
                    end
                end else begin
                    if (p > 10) bad[i] = 1'b1;
                    if (m_n == 10) begin
                        for (int j = 0; j < 11; j++) first11[10-j] = rx[j];
                        if (first11 != m_seed[i]) begin
                            serr_m[i] = 1'b1;
                            bad[i]    = 1'b1;
                        end
                    end
                end
                if (p == SET_BITS - 1) begin
                    exp_os[i]  = !bad[i] && (errs[i] == 0);
                    exp_blk[i] = !exp_os[i];
                    errs[i]    = 0;
                    bad[i]     = 1'b0;
                end
            end
            m_n++;
        end
        m_enq = enable;
    endtask

    task automatic check_inst(input int i, input logic l, input logic o, input logic b,
                              input logic [7:0] e, input logic s);
        chk("locked", i, {7'd0, l}, {7'd0, logic'(m_n >= acq_end[i])});
        chk("os_received", i, {7'd0, o}, {7'd0, exp_os[i]});
        chk("block_err", i, {7'd0, b}, {7'd0, exp_blk[i]});
        chk("err_cnt", i, e, 8'(errs[i]));
        chk("seed_err", i, {7'd0, s}, {7'd0, serr_m[i]});
        if (o) os_seen[i]++;
        if (b) blk_seen[i]++;
    endtask

    task automatic check_all();
        check_inst(0, locked0, os0, blk0, err0, serr0);
        check_inst(1, locked1, os1, blk1, err1, serr1);
    endtask

    task automatic step(input logic inv);
        data_in = txs[m_n] ^ inv;
        @(posedge clk);
        model_edge(data_in);
        #1;
        step_no++;
        check_all();
    endtask

    task automatic restart(input int gap);
        enable = 1'b0;
        repeat (gap) step(1'b0);
        enable = 1'b1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            os_seen[i] = 0; blk_seen[i] = 0;
        end
    endtask

    task automatic check_counts(input string tag, input int os_l0, input int blk_l0,
                                input int os_l1, input int blk_l1);
        chk({tag, "_os_count"}, 0, 8'(os_seen[0]), 8'(os_l0));
        chk({tag, "_blk_count"}, 0, 8'(blk_seen[0]), 8'(blk_l0));
        chk({tag, "_os_count"}, 1, 8'(os_seen[1]), 8'(os_l1));
        chk({tag, "_blk_count"}, 1, 8'(blk_seen[1]), 8'(blk_l1));
    endtask

    initial begin
        logic [10:0] s0;
        int bs, bl;
        s0 = 11'h7FF;
        m_seed[0] = 11'h7FF;
        m_seed[1] = 11'h770;
        for (int k = 0; k < 4096; k++) begin
            txs[k] = (k < 11) ? s0[10-k] : (txs[k-11] ^ txs[k-9]);
            rx[k]  = 1'b0;
        end
        model_reset();
        clear_counts();

        // Reset state
        #1 reset = 1'b0;
        #1 check_all();
        @(negedge clk) reset = 1'b1;
        repeat (2) step(1'b0);

        // Clean lane-0 stream for two sets
        clear_counts();
        enable = 1'b1;
        repeat (902) step(1'b0);
        check_counts("clean", 2, 0, 1, 1);

        // Single flipped bit at 200
        clear_counts();
        restart(3);
        repeat (900) step(m_n == 200);
        check_counts("flip200", 1, 1, 1, 1);

        // Four inverted bits at 300..303: lock loss and re-acquisition
        clear_counts();
        restart(3);
        repeat (900) step(m_n >= 300 && m_n <= 303);
        check_counts("burst300", 1, 1, 1, 1);

        // Enable gap of 20 cycles at bit 250
        clear_counts();
        restart(3);
        while (m_n < 250) step(1'b0);
        restart(20);
        repeat (462) step(1'b0);
        check_counts("gap", 1, 0, 0, 1);

        // Random sparse flips plus one random burst
        restart(3);
        bs = int'($urandom_range(100, 1200));
        bl = int'($urandom_range(1, 6));
        repeat (1346) step(($urandom_range(0, 199) == 0) || (m_n >= bs && m_n < bs + bl));

        // Asynchronous reset while locked
        restart(3);
        repeat (100) step(1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk) reset = 1'b1;
        repeat (30) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
